// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: bus layouts, FSM states, byte lanes.
// The packed structs fix the field order (MSB first), and therefore every field offset, of both buses.
package mem_pkg;

    localparam int EM_W   = 155;
    localparam int MW_W   = 119;
    localparam int BYTE_W = 8;

    localparam logic [3:0] LANE_BYTE0 = 4'b0001;
    localparam logic [3:0] LANE_WORD  = 4'b1111;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ISSUE = 2'd1,
        S_READY = 2'd2
    } state_t;

    typedef struct packed {
        logic        inst_load;
        logic        inst_store;
        logic        ls_word;
        logic        lb_sign;
        logic [31:0] store_data;
        logic [31:0] exe_result;
        logic [31:0] lo_result;
        logic        hi_write;
        logic        lo_write;
        logic        wen;
        logic [4:0]  wdest;
        logic        mfhi;
        logic        mflo;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  cp0r_addr;
        logic        syscall;
        logic        eret;
        logic        overflow;
        logic [31:0] pc;
    } em_bus_t;

    typedef struct packed {
        logic        wen;
        logic [4:0]  wdest;
        logic [31:0] mem_result;
        logic [31:0] lo_result;
        logic        hi_write;
        logic        lo_write;
        logic        mfhi;
        logic        mflo;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  cp0r_addr;
        logic        syscall;
        logic        eret;
        logic        overflow;
        logic [31:0] pc;
    } mw_bus_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data RAM: store enables and replicated data,
// and load byte extraction with sign or zero extension.
module mem_align
    import mem_pkg::*;
(
    input  logic        i_ls_word,
    input  logic        i_lb_sign,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [3:0]  o_wen_mask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_result
);

    logic [BYTE_W-1:0] w_byte;

    // NOTE: every output of a combinational block is assigned on every path so no latch is inferred.
    always_comb begin
        case (i_addr)
            2'd0:    w_byte = i_load_word[7:0];
            2'd1:    w_byte = i_load_word[15:8];
            2'd2:    w_byte = i_load_word[23:16];
            default: w_byte = i_load_word[31:24];
        endcase

        if (i_ls_word) begin
            o_wen_mask    = LANE_WORD;
            o_wdata       = i_store_data;
            o_load_result = i_load_word;
        end else begin
            o_wen_mask    = LANE_BYTE0 << i_addr;
            o_wdata       = {4{i_store_data[BYTE_W-1:0]}};
            o_load_result = {{24{i_lb_sign & w_byte[BYTE_W-1]}}, w_byte};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches EXE->MEM, drives the synchronous data RAM, builds MEM->WB.
// Define MEM_FWD_EN to drive the MEM-stage forwarding outputs; otherwise they are tied to 0.
module mem_stage
    import mem_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            EXE_over,
    input  logic [EM_W-1:0] EXE_MEM_bus,
    input  logic            WB_allow_in,
    input  logic            cancel,
    output logic            MEM_allow_in,
    output logic            MEM_valid,
    output logic            MEM_over,
    output logic [MW_W-1:0] MEM_WB_bus,
    output logic [4:0]      MEM_wdest,
    output logic [31:0]     dm_addr,
    output logic [3:0]      dm_wen,
    output logic [31:0]     dm_wdata,
    input  logic [31:0]     dm_rdata,
    output logic            MEM_fwd_valid,
    output logic [31:0]     MEM_fwd_data
);

    state_t      r_state;
    state_t      w_next_state;
    state_t      w_accept_state;
    logic        r_valid;
    em_bus_t     r_bus;
    em_bus_t     w_bus_in;
    logic [31:0] r_load_data;
    logic        w_accept;
    logic        w_handoff;
    logic [3:0]  w_wen_mask;
    logic [31:0] w_wdata;
    logic [31:0] w_load_result;
    logic [31:0] w_mem_result;
    mw_bus_t     w_wb;

    assign w_bus_in       = em_bus_t'(EXE_MEM_bus);
    assign MEM_valid      = r_valid;
    assign MEM_over       = (r_state == S_READY);
    assign MEM_allow_in   = !r_valid | (MEM_over & WB_allow_in);
    assign w_accept       = EXE_over & MEM_allow_in & !cancel;
    assign w_handoff      = MEM_over & WB_allow_in;
    assign w_accept_state = (w_bus_in.inst_load | w_bus_in.inst_store) ? S_ISSUE : S_READY;

    always_comb begin
        w_next_state = r_state;
        if (cancel) begin
            w_next_state = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) w_next_state = w_accept_state;
                S_ISSUE: w_next_state = S_READY;
                S_READY: begin
                    if (w_accept)         w_next_state = w_accept_state;
                    else if (WB_allow_in) w_next_state = S_EMPTY;
                end
                default: w_next_state = S_EMPTY;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_valid     <= 1'b0;
            r_bus       <= '0;
            r_load_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (cancel)         r_valid <= 1'b0;
            else if (w_accept)  r_valid <= 1'b1;
            else if (w_handoff) r_valid <= 1'b0;
            if (w_accept) r_bus <= w_bus_in;
            // RAM data for the address driven during S_ISSUE is sampled on the edge leaving it.
            if (r_state == S_ISSUE && r_bus.inst_load) r_load_data <= dm_rdata;
        end
    end

    mem_align u_align (
        .i_ls_word     (r_bus.ls_word),
        .i_lb_sign     (r_bus.lb_sign),
        .i_addr        (r_bus.exe_result[1:0]),
        .i_store_data  (r_bus.store_data),
        .i_load_word   (r_load_data),
        .o_wen_mask    (w_wen_mask),
        .o_wdata       (w_wdata),
        .o_load_result (w_load_result)
    );

    assign dm_addr      = {r_bus.exe_result[31:2], 2'b00};
    assign dm_wdata     = w_wdata;
    // Enables exist only in the single S_ISSUE cycle, so a stalled store never writes twice.
    assign dm_wen       = (r_state == S_ISSUE && r_bus.inst_store && !cancel) ? w_wen_mask : 4'b0000;
    assign w_mem_result = r_bus.inst_load ? w_load_result : r_bus.exe_result;
    assign MEM_wdest    = r_bus.wdest & {5{r_valid}};

    always_comb begin
        w_wb.wen        = r_bus.wen;
        w_wb.wdest      = r_bus.wdest;
        w_wb.mem_result = w_mem_result;
        w_wb.lo_result  = r_bus.lo_result;
        w_wb.hi_write   = r_bus.hi_write;
        w_wb.lo_write   = r_bus.lo_write;
        w_wb.mfhi       = r_bus.mfhi;
        w_wb.mflo       = r_bus.mflo;
        w_wb.mtc0       = r_bus.mtc0;
        w_wb.mfc0       = r_bus.mfc0;
        w_wb.cp0r_addr  = r_bus.cp0r_addr;
        w_wb.syscall    = r_bus.syscall;
        w_wb.eret       = r_bus.eret;
        w_wb.overflow   = r_bus.overflow;
        w_wb.pc         = r_bus.pc;
    end

    assign MEM_WB_bus = w_wb;

`ifdef MEM_FWD_EN
    assign MEM_fwd_valid = MEM_over & r_bus.wen;
    assign MEM_fwd_data  = w_mem_result;
`else
    assign MEM_fwd_valid = 1'b0;
    assign MEM_fwd_data  = 32'd0;
`endif

endmodule
